// File: rtl/mycpu_mc_core.sv
// Multi-cycle LoongArch32 subset core: IF/EX/MEM/WB sequencer over req/ack
// instruction and data buses, with a write-back trace port and bus watchdog.
module mycpu_mc_core #(
    parameter logic [31:0] RESET_PC = 32'h1bc00000,
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_ack,
    input  logic [31:0] inst_rdata,
    output logic        data_req,
    output logic        data_wr,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_ack,
    input  logic [31:0] data_rdata,
    output logic [31:0] debug_wb_pc,
    output logic        debug_wb_rf_we,
    output logic [4:0]  debug_wb_rf_wnum,
    output logic [31:0] debug_wb_rf_wdata,
    output logic        inst_illegal,
    output logic        bus_err
);
    typedef enum logic [2:0] {S_IF, S_EX, S_MEM, S_WB, S_HALT} state_t;

    localparam bit          WDOG_EN   = (MAX_WAIT != 0);
    localparam logic [31:0] WAIT_LAST = (MAX_WAIT == 0) ? 32'd0 : 32'(MAX_WAIT - 1);

    state_t      state_q;
    logic [31:0] pc_q, ir_q, next_pc_q, wait_q;
    logic        inst_req_q, data_req_q, data_wr_q, is_load_q;
    logic [31:0] data_addr_q, data_wdata_q;
    logic [31:0] wb_pc_q, wb_wdata_q;
    logic [4:0]  wb_wnum_q;
    logic        wb_we_q, illegal_q, bus_err_q;
    logic [31:0] rj_val_q, rk_val_q;
    logic [31:0] rf_mem [0:31];

    // Decode of the latched instruction
    logic        op_add, op_sub, op_addi, op_ld, op_st, op_beq, op_bne, op_b;
    logic [4:0]  rd;
    logic [31:0] simm, br_off16, br_off26;

    assign op_add   = (ir_q[31:15] == 17'h00020);
    assign op_sub   = (ir_q[31:15] == 17'h00022);
    assign op_addi  = (ir_q[31:22] == 10'h00a);
    assign op_ld    = (ir_q[31:22] == 10'h0a2);
    assign op_st    = (ir_q[31:22] == 10'h0a6);
    assign op_beq   = (ir_q[31:26] == 6'h16);
    assign op_bne   = (ir_q[31:26] == 6'h17);
    assign op_b     = (ir_q[31:26] == 6'h14);
    assign rd       = ir_q[4:0];
    assign simm     = {{20{ir_q[21]}}, ir_q[21:10]};
    assign br_off16 = {{14{ir_q[25]}}, ir_q[25:10], 2'b00};
    assign br_off26 = {{4{ir_q[9]}}, ir_q[9:0], ir_q[25:10], 2'b00};

    logic [31:0] alu_res_d, next_pc_d;
    logic        wb_we_d, legal_d;

    always_comb begin
        alu_res_d = 32'd0;
        next_pc_d = pc_q + 32'd4;
        wb_we_d   = 1'b0;
        legal_d   = op_add | op_sub | op_addi | op_ld | op_st | op_beq | op_bne | op_b;
        if (op_add) begin
            alu_res_d = rj_val_q + rk_val_q;
            wb_we_d   = 1'b1;
        end else if (op_sub) begin
            alu_res_d = rj_val_q - rk_val_q;
            wb_we_d   = 1'b1;
        end else if (op_addi || op_ld || op_st) begin
            alu_res_d = rj_val_q + simm;
            wb_we_d   = op_addi;
        end
        if ((op_beq && (rj_val_q == rk_val_q)) || (op_bne && (rj_val_q != rk_val_q))) begin
            next_pc_d = pc_q + br_off16;
        end
        if (op_b) begin
            next_pc_d = pc_q + br_off26;
        end
    end

    // Register file: read on fetch completion, written at the end of WB
    logic       fetch_uses_rd;
    logic [4:0] rj_addr, rk_addr;

    assign fetch_uses_rd = (inst_rdata[31:22] == 10'h0a6) || (inst_rdata[31:26] == 6'h16)
                         || (inst_rdata[31:26] == 6'h17);
    assign rj_addr = inst_rdata[9:5];
    assign rk_addr = fetch_uses_rd ? inst_rdata[4:0] : inst_rdata[14:10];

    always_ff @(posedge clk) begin
        if (state_q == S_WB && wb_we_q) begin
            rf_mem[wb_wnum_q] <= wb_wdata_q;
        end
        if (state_q == S_IF && inst_req_q && inst_ack) begin
            rj_val_q <= (rj_addr == 5'd0) ? 32'd0 : rf_mem[rj_addr];
            rk_val_q <= (rk_addr == 5'd0) ? 32'd0 : rf_mem[rk_addr];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IF;
            pc_q         <= RESET_PC;
            ir_q         <= 32'd0;
            next_pc_q    <= 32'd0;
            wait_q       <= 32'd0;
            inst_req_q   <= 1'b0;
            data_req_q   <= 1'b0;
            data_wr_q    <= 1'b0;
            is_load_q    <= 1'b0;
            data_addr_q  <= 32'd0;
            data_wdata_q <= 32'd0;
            wb_pc_q      <= 32'd0;
            wb_wdata_q   <= 32'd0;
            wb_wnum_q    <= 5'd0;
            wb_we_q      <= 1'b0;
            illegal_q    <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IF: begin
                    if (!inst_req_q) begin
                        inst_req_q <= 1'b1;
                        wait_q     <= 32'd0;
                    end else if (inst_ack) begin
                        ir_q       <= inst_rdata;
                        inst_req_q <= 1'b0;
                        state_q    <= S_EX;
                    end else if (WDOG_EN && wait_q == WAIT_LAST) begin
                        inst_req_q <= 1'b0;
                        bus_err_q  <= 1'b1;
                        state_q    <= S_HALT;
                    end else begin
                        wait_q <= wait_q + 32'd1;
                    end
                end
                S_EX: begin
                    next_pc_q <= next_pc_d;
                    if (op_ld || op_st) begin
                        data_req_q   <= 1'b1;
                        data_wr_q    <= op_st;
                        data_addr_q  <= alu_res_d;
                        data_wdata_q <= rk_val_q;
                        is_load_q    <= op_ld;
                        wait_q       <= 32'd0;
                        state_q      <= S_MEM;
                    end else begin
                        wb_pc_q    <= pc_q;
                        wb_wnum_q  <= rd;
                        wb_wdata_q <= alu_res_d;
                        wb_we_q    <= wb_we_d && (rd != 5'd0);
                        illegal_q  <= !legal_d;
                        state_q    <= S_WB;
                    end
                end
                S_MEM: begin
                    if (data_ack) begin
                        data_req_q <= 1'b0;
                        wb_pc_q    <= pc_q;
                        wb_wnum_q  <= rd;
                        wb_wdata_q <= is_load_q ? data_rdata : 32'd0;
                        wb_we_q    <= is_load_q && (rd != 5'd0);
                        state_q    <= S_WB;
                    end else if (WDOG_EN && wait_q == WAIT_LAST) begin
                        data_req_q <= 1'b0;
                        bus_err_q  <= 1'b1;
                        state_q    <= S_HALT;
                    end else begin
                        wait_q <= wait_q + 32'd1;
                    end
                end
                S_WB: begin
                    pc_q       <= next_pc_q;
                    wb_pc_q    <= 32'd0;
                    wb_wnum_q  <= 5'd0;
                    wb_wdata_q <= 32'd0;
                    wb_we_q    <= 1'b0;
                    illegal_q  <= 1'b0;
                    inst_req_q <= 1'b1;
                    wait_q     <= 32'd0;
                    state_q    <= S_IF;
                end
                S_HALT: begin
                    state_q <= S_HALT;
                end
                default: begin
                    state_q <= S_HALT;
                end
            endcase
        end
    end

    assign inst_req          = inst_req_q;
    assign inst_addr         = pc_q;
    assign data_req          = data_req_q;
    assign data_wr           = data_wr_q;
    assign data_addr         = data_addr_q;
    assign data_wdata        = data_wdata_q;
    assign debug_wb_pc       = wb_pc_q;
    assign debug_wb_rf_we    = wb_we_q;
    assign debug_wb_rf_wnum  = wb_wnum_q;
    assign debug_wb_rf_wdata = wb_wdata_q;
    assign inst_illegal      = illegal_q;
    assign bus_err           = bus_err_q;
endmodule

// File: tb/tb_mycpu_mc_core.sv
// Bench for mycpu_mc_core: program-driven runs against a variable-latency
// memory responder, with write-back events checked from a scoreboard queue.
module tb_mycpu_mc_core;
    localparam logic [31:0] P = 32'h1bc00000;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        inst_req, inst_ack, data_req, data_wr, data_ack;
    logic [31:0] inst_addr, inst_rdata, data_addr, data_wdata, data_rdata;
    logic [31:0] debug_wb_pc, debug_wb_rf_wdata;
    logic        debug_wb_rf_we, inst_illegal, bus_err;
    logic [4:0]  debug_wb_rf_wnum;

    mycpu_mc_core #(.MAX_WAIT(4)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_ack(inst_ack), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_ack(data_ack), .data_rdata(data_rdata),
        .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
        .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata),
        .inst_illegal(inst_illegal), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc; logic we; logic [4:0] wnum; logic [31:0] wdata; logic ill; } ev_t;
    typedef struct { logic [31:0] addr; logic wr; logic [31:0] wdata; } dacc_t;

    ev_t         exp_q[$];
    logic [31:0] flog[$];
    dacc_t       dlog[$];
    logic [31:0] imem [0:1023];
    logic [31:0] dmem [logic [31:0]];
    int          n_checks = 0;
    int          n_pass = 0;
    int          inst_wait = 0;
    int          data_wait = 0;
    bit          inst_en = 1'b1;

    function automatic logic [31:0] enc_i12(input logic [9:0] op, input logic [4:0] rd_f,
                                            input logic [4:0] rj_f, input logic [11:0] imm);
        return {op, imm, rj_f, rd_f};
    endfunction
    function automatic logic [31:0] enc_r(input logic [16:0] op, input logic [4:0] rd_f,
                                          input logic [4:0] rj_f, input logic [4:0] rk_f);
        return {op, rk_f, rj_f, rd_f};
    endfunction
    function automatic logic [31:0] enc_br(input logic [5:0] op, input logic [4:0] rj_f,
                                           input logic [4:0] rd_f, input logic [15:0] offs);
        return {op, offs, rj_f, rd_f};
    endfunction
    function automatic logic [31:0] enc_b(input logic [25:0] offs);
        return {6'h14, offs[15:0], offs[25:16]};
    endfunction
    function automatic ev_t ev(input logic [31:0] pc, input logic we, input logic [4:0] wnum,
                               input logic [31:0] wdata, input logic ill);
        ev_t e;
        e.pc = pc; e.we = we; e.wnum = wnum; e.wdata = wdata; e.ill = ill;
        return e;
    endfunction

    // Memory responder: acks after inst_wait/data_wait idle cycles of req
    initial begin
        int icnt = 0;
        int dcnt = 0;
        logic [31:0] off;
        dacc_t d;
        inst_ack = 1'b0; inst_rdata = 32'd0; data_ack = 1'b0; data_rdata = 32'd0;
        forever begin
            @(negedge clk);
            if (resetn && inst_req && inst_en) begin
                if (icnt >= inst_wait) begin
                    off = (inst_addr - P) >> 2;
                    inst_ack = 1'b1;
                    inst_rdata = imem[off[9:0]];
                    flog.push_back(inst_addr);
                    icnt = 0;
                end else begin
                    inst_ack = 1'b0;
                    icnt++;
                end
            end else begin
                inst_ack = 1'b0;
                icnt = 0;
            end
            if (resetn && data_req) begin
                d.addr = data_addr; d.wr = data_wr; d.wdata = data_wdata;
                dlog.push_back(d);
                if (dcnt >= data_wait) begin
                    data_ack = 1'b1;
                    if (data_wr) dmem[data_addr] = data_wdata;
                    else data_rdata = dmem.exists(data_addr) ? dmem[data_addr] : 32'd0;
                    dcnt = 0;
                end else begin
                    data_ack = 1'b0;
                    dcnt++;
                end
            end else begin
                data_ack = 1'b0;
                dcnt = 0;
            end
        end
    end

    // Scoreboard: every write-back pulse is matched against the next expectation
    initial begin
        ev_t e;
        forever begin
            @(negedge clk);
            if (resetn && (debug_wb_rf_we || inst_illegal)) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL wb_unexpected: pc=%h we=%b wnum=%0d wdata=%h ill=%b, required no event",
                             debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata, inst_illegal);
                end else begin
                    e = exp_q.pop_front();
                    if (debug_wb_pc !== e.pc || debug_wb_rf_we !== e.we || inst_illegal !== e.ill ||
                        (e.we && (debug_wb_rf_wnum !== e.wnum || debug_wb_rf_wdata !== e.wdata))) begin
                        $display("FAIL wb_event: got pc=%h we=%b r%0d=%h ill=%b, required pc=%h we=%b r%0d=%h ill=%b",
                                 debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata, inst_illegal,
                                 e.pc, e.we, e.wnum, e.wdata, e.ill);
                    end else begin
                        n_pass++;
                        $display("wb pc=%h we=%b r%0d=%h ill=%b", debug_wb_pc, debug_wb_rf_we,
                                 debug_wb_rf_wnum, debug_wb_rf_wdata, inst_illegal);
                    end
                end
            end
        end
    end

    task automatic load_spin();
        for (int i = 0; i < 1024; i++) imem[i] = 32'h50000000;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        exp_q.delete(); flog.delete(); dlog.delete(); dmem.delete();
        resetn = 1'b1;
    endtask

    task automatic wait_drain(input string name, input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL %s_drain: %0d events outstanding, required 0", name, exp_q.size());
        else n_pass++;
    endtask

    task automatic test_reset();
        load_spin();
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({inst_req, data_req, debug_wb_rf_we, inst_illegal, bus_err} !== 5'b0 ||
            debug_wb_pc !== 32'd0 || debug_wb_rf_wdata !== 32'd0 || debug_wb_rf_wnum !== 5'd0) begin
            $display("FAIL reset_outputs: req=%b/%b we=%b ill=%b err=%b pc=%h, required all 0",
                     inst_req, data_req, debug_wb_rf_we, inst_illegal, bus_err, debug_wb_pc);
        end else n_pass++;
        resetn = 1'b1;
        @(negedge clk);
        n_checks++;
        if (inst_req !== 1'b1 || inst_addr !== P) begin
            $display("FAIL reset_first_fetch: req=%b addr=%h, required 1 %h", inst_req, inst_addr, P);
        end else n_pass++;
        $display("reset: first fetch req=%b addr=%h", inst_req, inst_addr);
    endtask

    task automatic test_alu();
        int cyc = 0;
        int wb_cyc[$];
        load_spin();
        imem[0] = enc_i12(10'h00a, 5'd1, 5'd0, 12'd5);
        imem[1] = enc_r(17'h00020, 5'd2, 5'd1, 5'd1);
        imem[2] = enc_r(17'h00022, 5'd3, 5'd0, 5'd1);
        imem[3] = enc_i12(10'h00a, 5'd0, 5'd0, 12'd7);
        imem[4] = enc_r(17'h00020, 5'd5, 5'd0, 5'd0);
        inst_wait = 0; data_wait = 0;
        do_reset();
        exp_q.push_back(ev(P,      1'b1, 5'd1, 32'd5,        1'b0));
        exp_q.push_back(ev(P + 4,  1'b1, 5'd2, 32'd10,       1'b0));
        exp_q.push_back(ev(P + 8,  1'b1, 5'd3, 32'hfffffffb, 1'b0));
        exp_q.push_back(ev(P + 16, 1'b1, 5'd5, 32'd0,        1'b0));
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) begin
            @(negedge clk);
            cyc++;
            if (debug_wb_rf_we) wb_cyc.push_back(cyc);
        end
        wait_drain("alu", 20);
        n_checks++;
        if (wb_cyc.size() < 2 || wb_cyc[0] != 3 || wb_cyc[1] != 6) begin
            $display("FAIL alu_latency: first wb cycles %0d,%0d, required 3,6",
                     wb_cyc.size() > 0 ? wb_cyc[0] : -1, wb_cyc.size() > 1 ? wb_cyc[1] : -1);
        end else n_pass++;
    endtask

    task automatic test_store_load();
        int st_n = 0;
        int ld_n = 0;
        bit st_bad = 1'b0;
        load_spin();
        imem[0] = enc_i12(10'h00a, 5'd2, 5'd0, 12'd10);
        imem[1] = enc_i12(10'h0a6, 5'd2, 5'd0, 12'h100);
        imem[2] = enc_i12(10'h0a2, 5'd4, 5'd0, 12'h100);
        inst_wait = 0; data_wait = 3;
        do_reset();
        exp_q.push_back(ev(P,     1'b1, 5'd2, 32'd10, 1'b0));
        exp_q.push_back(ev(P + 8, 1'b1, 5'd4, 32'd10, 1'b0));
        wait_drain("mem", 80);
        foreach (dlog[i]) begin
            if (dlog[i].wr) begin
                st_n++;
                if (dlog[i].addr !== 32'h100 || dlog[i].wdata !== 32'd10) st_bad = 1'b1;
            end else begin
                ld_n++;
                if (dlog[i].addr !== 32'h100) st_bad = 1'b1;
            end
        end
        n_checks++;
        if (st_n != 4 || ld_n != 4) $display("FAIL mem_req_cycles: store %0d load %0d, required 4 4", st_n, ld_n);
        else n_pass++;
        n_checks++;
        if (st_bad) $display("FAIL mem_stable: addr/wdata varied during req, required 0x100/10 throughout");
        else n_pass++;
        $display("mem: store req cycles=%0d load req cycles=%0d", st_n, ld_n);
    endtask

    task automatic test_branch();
        logic [31:0] exp_f [0:8];
        load_spin();
        imem[0]   = enc_i12(10'h00a, 5'd1, 5'd0, 12'd1);
        imem[1]   = enc_i12(10'h00a, 5'd2, 5'd0, 12'd2);
        imem[2]   = enc_br(6'h16, 5'd1, 5'd2, 16'd8);
        imem[3]   = enc_b(26'd2);
        imem[4]   = enc_b(26'h100);
        imem[5]   = enc_i12(10'h00a, 5'd6, 5'd0, 12'h033);
        imem[6]   = enc_br(6'h17, 5'd1, 5'd2, 16'hfffe);
        imem[260] = enc_i12(10'h00a, 5'd7, 5'd0, 12'h044);
        exp_f = '{P, P + 4, P + 8, P + 12, P + 20, P + 24, P + 16, P + 32'h410, P + 32'h414};
        inst_wait = 1; data_wait = 0;
        do_reset();
        exp_q.push_back(ev(P,            1'b1, 5'd1, 32'd1,    1'b0));
        exp_q.push_back(ev(P + 4,        1'b1, 5'd2, 32'd2,    1'b0));
        exp_q.push_back(ev(P + 20,       1'b1, 5'd6, 32'h33,   1'b0));
        exp_q.push_back(ev(P + 32'h410,  1'b1, 5'd7, 32'h44,   1'b0));
        for (int i = 0; i < 200 && flog.size() < 9; i++) @(negedge clk);
        wait_drain("branch", 20);
        n_checks++;
        if (flog.size() < 9) $display("FAIL branch_fetch_count: %0d fetches, required >= 9", flog.size());
        else n_pass++;
        for (int i = 0; i < 9 && i < flog.size(); i++) begin
            n_checks++;
            if (flog[i] !== exp_f[i]) $display("FAIL branch_fetch_%0d: addr %h, required %h", i, flog[i], exp_f[i]);
            else n_pass++;
            $display("fetch %0d addr=%h", i, flog[i]);
        end
    endtask

    task automatic test_illegal();
        load_spin();
        imem[0] = 32'hffffffff;
        imem[1] = enc_i12(10'h00a, 5'd8, 5'd0, 12'd3);
        inst_wait = 0; data_wait = 0;
        do_reset();
        exp_q.push_back(ev(P,     1'b0, 5'd0, 32'd0, 1'b1));
        exp_q.push_back(ev(P + 4, 1'b1, 5'd8, 32'd3, 1'b0));
        wait_drain("illegal", 40);
    endtask

    task automatic test_timeout();
        int req_n = 0;
        load_spin();
        inst_en = 1'b0;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (inst_req) req_n++;
        end
        n_checks++;
        if (req_n != 4) $display("FAIL timeout_wait_cycles: %0d, required 4", req_n);
        else n_pass++;
        n_checks++;
        if (bus_err !== 1'b1 || inst_req !== 1'b0 || data_req !== 1'b0)
            $display("FAIL timeout_halt: err=%b req=%b/%b, required 1 0 0", bus_err, inst_req, data_req);
        else n_pass++;
        $display("timeout: req cycles=%0d bus_err=%b", req_n, bus_err);
        resetn = 1'b0;
        #1;
        n_checks++;
        if (bus_err !== 1'b0) $display("FAIL timeout_clear: bus_err=%b, required 0", bus_err);
        else n_pass++;
        inst_en = 1'b1;
    endtask

    task automatic test_reset_mid_mem();
        bit seen = 1'b0;
        load_spin();
        imem[0] = enc_i12(10'h0a2, 5'd9, 5'd0, 12'h100);
        inst_wait = 0; data_wait = 2;
        do_reset();
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = data_req;
        end
        n_checks++;
        if (!seen) $display("FAIL midmem_req: data_req never rose, required 1");
        else n_pass++;
        resetn = 1'b0;
        #1;
        n_checks++;
        if (data_req !== 1'b0 || inst_req !== 1'b0 || debug_wb_rf_we !== 1'b0)
            $display("FAIL midmem_drop: data_req=%b inst_req=%b we=%b, required 0 0 0",
                     data_req, inst_req, debug_wb_rf_we);
        else n_pass++;
        $display("midmem: data_req after reset=%b", data_req);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_alu();
        test_store_load();
        test_branch();
        test_illegal();
        test_timeout();
        test_reset_mid_mem();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
